// File: rtl/led_fade_pwm.sv
// PIO-driven LED fader: each channel's brightness ramps linearly toward full-on
// or full-off, and the brightness is rendered as a 256-clock PWM on the LED pin.
module led_fade_pwm #(
  parameter int NUM_LED  = 8,
  parameter int STEP_DIV = 19531
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic [NUM_LED-1:0] pio_in,
  input  logic               fade_en,
  output logic [NUM_LED-1:0] led_out,
  output logic               settled
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DIV - 1);

  logic [NUM_LED-1:0] r_target_q;
  logic [CNT_W-1:0]   r_step_cnt;
  logic [7:0]         r_pwm_cnt;
  logic               r_settled;
  logic               w_tick;
  logic [NUM_LED-1:0] w_at_target;
  logic [NUM_LED-1:0] w_led;

  // With STEP_DIV = 1 the counter is pinned at 0 and every cycle is a tick.
  assign w_tick = (r_step_cnt == STEP_LAST);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_target_q <= '0;
      r_step_cnt <= '0;
      r_pwm_cnt  <= '0;
      r_settled  <= 1'b1;
    end else begin
      r_target_q <= pio_in;
      r_step_cnt <= w_tick ? '0 : r_step_cnt + 1'b1;
      r_pwm_cnt  <= r_pwm_cnt + 8'd1;
      r_settled  <= &w_at_target;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LED; gi++) begin : g_chan
      logic [7:0] r_bright;
      logic       r_led;
      logic [7:0] w_level;

      assign w_level         = {8{r_target_q[gi]}};
      assign w_at_target[gi] = (r_bright == w_level);
      assign w_led[gi]       = r_led;

      always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
          r_bright <= 8'd0;
          r_led    <= 1'b0;
        end else begin
          r_led <= (r_bright == 8'hFF) | (r_bright > r_pwm_cnt);
          if (!fade_en) begin
            r_bright <= w_level;
          end else if (w_tick && !w_at_target[gi]) begin
            // Target is only ever 0 or 255, so stepping toward it cannot wrap.
            r_bright <= r_target_q[gi] ? r_bright + 8'd1 : r_bright - 8'd1;
          end
        end
      end
    end
  endgenerate

  assign led_out = w_led;
  assign settled = r_settled;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: a cycle-level reference model feeds a scoreboard queue
// that a negedge monitor drains against led_out/settled, plus directed checks.
module tb_led_fade_pwm;

  localparam int N  = 8;
  localparam int SD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] pio = '0;
  logic         fen = 1'b0;
  logic [N-1:0] led;
  logic         settled;

  always #5 clk = ~clk;

  led_fade_pwm #(.NUM_LED(N), .STEP_DIV(SD)) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .pio_in     (pio),
    .fade_en    (fen),
    .led_out    (led),
    .settled    (settled)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [N-1:0] led;
    logic         settled;
  } exp_t;

  exp_t q[$];
  exp_t e;

  // Reference model: time since reset gives the prescaler and PWM phase directly.
  bit           m_on = 0;
  int           m_n;
  int           m_bright[N];
  logic [N-1:0] m_target;
  logic [N-1:0] m_led;
  logic         m_set;
  logic [N-1:0] n_led;
  logic         n_set;
  int           m_pwm;
  int           m_lvl;
  bit           m_tick;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1;
      m_n = 0;
      m_target = '0;
      for (int i = 0; i < N; i++) m_bright[i] = 0;
      m_led = '0;
      m_set = 1'b1;
    end else if (m_on) begin
      m_pwm  = m_n % 256;
      m_tick = ((m_n % SD) == SD - 1);
      n_set  = 1'b1;
      for (int i = 0; i < N; i++) begin
        m_lvl = m_target[i] ? 255 : 0;
        n_led[i] = (m_bright[i] == 255) || (m_bright[i] > m_pwm);
        if (m_bright[i] != m_lvl) n_set = 1'b0;
        if (!fen) m_bright[i] = m_lvl;
        else if (m_tick && m_bright[i] < m_lvl) m_bright[i] = m_bright[i] + 1;
        else if (m_tick && m_bright[i] > m_lvl) m_bright[i] = m_bright[i] - 1;
      end
      m_target = pio;
      m_led = n_led;
      m_set = n_set;
      m_n++;
    end
    if (m_on) q.push_back({m_led, m_set});
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if (led !== e.led || settled !== e.settled) begin
        fails++;
        $display("FAIL scoreboard t=%0t: led_out=%h settled=%b, expected led_out=%h settled=%b",
                 $time, led, settled, e.led, e.settled);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    tests++;
    if (got < lo || got > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic wait_bright(input string name, input int ch, input int val, input int bound);
    int k = 0;
    while (m_bright[ch] != val && k < bound) begin
      step(1);
      k++;
    end
    tests++;
    if (m_bright[ch] != val) begin
      fails++;
      $display("FAIL %s: timeout after %0d cycles, bright=%0d, expected %0d", name, k, m_bright[ch], val);
    end
  endtask

  int k;
  int hi_cnt;

  initial begin
    // Reset held two cycles with every PIO bit requesting on.
    pio = 8'hFF; fen = 1'b1; rst = 1'b1;
    step(2);
    rst = 1'b0;
    check("reset_led", led, 8'h00);
    check("reset_settled", {7'd0, settled}, 8'h01);
    pio = 8'h00;
    step(5);
    $display("[TB] reset done");

    // Fade up on channel 0.
    pio = 8'h01;
    step(2);
    check("fade_up_settled_drop", {7'd0, settled}, 8'h00);
    k = 2;
    while (settled !== 1'b1 && k < 1100) begin
      step(1);
      k++;
    end
    check_range("fade_up_settle_cycles", k, 1019, 1022);
    check("fade_up_led", led, 8'h01);
    $display("[TB] fade up settled after %0d cycles", k);

    // Reversal at brightness 100.
    fen = 1'b0; pio = 8'h00; step(3);
    fen = 1'b1; pio = 8'h01;
    wait_bright("rev_reach_100", 0, 100, 600);
    pio = 8'h00;
    wait_bright("rev_reach_0", 0, 0, 600);
    step(2);
    check("rev_settled", {7'd0, settled}, 8'h01);
    check("rev_led", led, 8'h00);
    $display("[TB] reversal done");

    // Bypass: jump straight to target.
    fen = 1'b0; pio = 8'h00; step(3);
    pio = 8'hA5;
    step(3);
    check("bypass_led_c3", led, 8'hA5);
    check("bypass_settled_c3", {7'd0, settled}, 8'h01);
    step(100);
    check("bypass_led_c103", led, 8'hA5);
    $display("[TB] bypass done");

    // PWM duty: hover channel 3 around 64 by alternating its target every tick.
    fen = 1'b0; pio = 8'h00; step(3);
    fen = 1'b1; pio = 8'h08;
    wait_bright("pwm_reach_64", 3, 64, 400);
    hi_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (i % SD == 0) pio[3] = ~pio[3];
      step(1);
      hi_cnt += int'(led[3]);
    end
    check_range("pwm_duty_ch3", hi_cnt, 60, 68);
    $display("[TB] pwm duty high count %0d", hi_cnt);

    // Reset mid-fade.
    fen = 1'b0; pio = 8'h00; step(3);
    fen = 1'b1; pio = 8'h01;
    wait_bright("midfade_reach_37", 0, 37, 300);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midfade_reset_led", led, 8'h00);
    check("midfade_reset_settled", {7'd0, settled}, 8'h01);
    step(3);
    check("midfade_restart_settled", {7'd0, settled}, 8'h00);
    wait_bright("midfade_restart_5", 0, 5, 100);
    $display("[TB] reset mid-fade done");

    // Randomized traffic, including occasional resets.
    for (int t = 0; t < 60; t++) begin
      pio = N'($urandom);
      fen = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 30) == 0);
      step($urandom_range(1, 60));
      rst = 1'b0;
      $display("[TB] random txn %0d pio=%h fade_en=%b", t, pio, fen);
    end
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
